// File: rtl/guess_key_conditioner_if.sv
// guess_key_conditioner_if: raw key lines in, debounced guess levels and flags out
interface guess_key_conditioner_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] KEY;
  logic [WIDTH-1:0] G;
  logic [WIDTH-1:0] press;
  logic             multi;
  logic             idle;
  modport master (output KEY, input G, press, multi, idle);
  modport slave (input KEY, output G, press, multi, idle);
endinterface

// File: rtl/guess_key_conditioner.sv
// guess_key_conditioner: synchronise and debounce raw key lines into clean guess levels
module guess_key_conditioner #(
  parameter int WIDTH = 10,
  parameter int DB_CYCLES = 16
) (
  input logic                    clk,
  input logic                    reset,
  guess_key_conditioner_if.slave bus
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, g_q, g_d, press_q, press_d, done;
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  // two-flop sync, then per-bit mismatch counter that commits s2 to G after a full stable run
  always_comb begin
    s1_d = bus.KEY;
    s2_d = s1_q;
    g_d = g_q;
    press_d = '0;
    done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      done[i] = (s2_q[i] != g_q[i]) && (cnt_q[i] == CNT_MAX);
      cnt_d[i] = (s2_q[i] != g_q[i] && !done[i]) ? cnt_q[i] + 1'b1 : '0;
      g_d[i] = done[i] ? s2_q[i] : g_q[i];
      press_d[i] = done[i] & s2_q[i];
    end
  end
  // state registers; reset drops everything at once so partial counts never survive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      g_q <= '0;
      press_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      g_q <= g_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.G = g_q;
  assign bus.press = press_q;
  assign bus.multi = |(g_q & (g_q - 1'b1));
  assign bus.idle = ~|g_q;
endmodule
